tracklet_par_read_arbiter: RTL and testbench

Shares the single read port of the tracklet-parameter memory between two requesters (A and B), such as downstream projection or match engines. It tracks the BX page being read, with the reader one page behind the writer. It bounds-checks each request against the entry count of that page and issues round-robin reads to the memory. It returns the read data tagged to the requester that asked for it after the memory's registered-output latency.

---
 rtl/trkpar_pkg.sv | 43 ++++
 rtl/rr_arb2.sv | 43 ++++
 rtl/tracklet_par_read_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_tracklet_par_read_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/trkpar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trkpar_pkg
//  Description : Shared definitions for the tracklet-parameter read arbiter:
//                parameter defaults, response tag type, requester ids and the
//                read-page (rd_bx) reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
package trkpar_pkg;

    // Defaults for the arbiter parameters
    localparam int c_addr_w = 6;   // entry index width within one BX page
    localparam int c_bx_w   = 5;   // BX page-select width
    localparam int c_data_w = 68;  // memory word width
    localparam int c_rd_lat = 2;   // output-registered RAM read latency

    // The reader trails the writer by one page; after reset the writer sits on
    // page all-ones, so the reader starts one page behind it.
    localparam logic [c_bx_w-1:0] c_rd_bx_rst = 5'b11110;

    // Saturation limit of the optional statistics counters
    localparam logic [15:0] c_stat_max = 16'hFFFF;

    // Requester identity carried in the response tag
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Response tag travelling alongside the memory read
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    hit;
    } trk_tag_t;

    // Generic form of the rd_bx reset value for any page-select width
    function automatic int unsigned rd_bx_rst_val(input int unsigned bx_w);
        return (32'd1 << bx_w) - 32'd2;
    endfunction

endpackage : trkpar_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin arbiter with combinational grants.
//                A lone requester is granted at once; on contention the
//                favoured requester wins and the pointer then flips to the
//                other one. The pointer only moves on contested grants.
//  Ports       : clk    - clock
//                reset  - synchronous active-low reset (pointer favours A)
//                clr    - synchronous active-high clear (pointer favours A)
//                en     - grant enable
//                req    - requests, bit 0 = A, bit 1 = B
//                gnt    - one-hot-or-zero grants, bit 0 = A, bit 1 = B
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0 = A favoured on contention, 1 = B favoured
    logic r_prio;
    logic w_both;

    assign w_both = req[0] & req[1];

    assign gnt[0] = en & req[0] & (~req[1] | ~r_prio);
    assign gnt[1] = en & req[1] & (~req[0] |  r_prio);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            r_prio <= 1'b0;
        end else if (en && w_both) begin
            r_prio <= ~r_prio;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/tracklet_par_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tracklet_par_read_arbiter
//  Description : Shares the single read port of the tracklet-parameter memory
//                between requesters A and B. Tracks the BX page being read
//                (one page behind the writer), bounds-checks each request
//                against the page entry count, issues round-robin reads and
//                returns tagged responses after the RAM read latency.
//  Ports       : clk, reset (sync active-low)
//                en_proc            - processing enable
//                start[1:0]         - [0] new-BX strobe, [1] pipelined reset
//                done[1:0]          - start delayed by one clock
//                nent               - valid entries in the page being read
//                req_a/b, idx_a/b   - level-held requests and entry indices
//                gnt_a/b            - combinational grants
//                read_add           - registered memory read address
//                mem_dout           - memory read data
//                vld_a/b, hit_a/b   - response valid / in-range flags
//                dout               - response data (0 on rejected index)
//                stat_gnt_a/b, stat_conflict - only with TRKPAR_ARB_STATS_EN
//  Config      : define TRKPAR_ARB_STATS_EN to add the saturating grant and
//                contention counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tracklet_par_read_arbiter
    import trkpar_pkg::*;
#(
    parameter int ADDR_W = c_addr_w,
    parameter int BX_W   = c_bx_w,
    parameter int DATA_W = c_data_w,
    parameter int RD_LAT = c_rd_lat
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_proc,
    input  logic [1:0]             start,
    output logic [1:0]             done,
    input  logic [ADDR_W:0]        nent,
    input  logic                   req_a,
    input  logic                   req_b,
    input  logic [ADDR_W-1:0]      idx_a,
    input  logic [ADDR_W-1:0]      idx_b,
    output logic                   gnt_a,
    output logic                   gnt_b,
    output logic [BX_W+ADDR_W-1:0] read_add,
    input  logic [DATA_W-1:0]      mem_dout,
    output logic                   vld_a,
    output logic                   vld_b,
    output logic                   hit_a,
    output logic                   hit_b,
    output logic [DATA_W-1:0]      dout
`ifdef TRKPAR_ARB_STATS_EN
    ,
    output logic [15:0]            stat_gnt_a,
    output logic [15:0]            stat_gnt_b,
    output logic [15:0]            stat_conflict
`endif
);

    localparam logic [BX_W-1:0] c_bx_rst = BX_W'(rd_bx_rst_val(BX_W));

    // ------------------------------------------------------------------------
    // Control qualifiers
    // ------------------------------------------------------------------------
    logic w_rst_any;     // either reset condition
    logic w_gnt_en;      // grants allowed this cycle
    logic [1:0] w_gnt;
    logic w_any_gnt;
    logic [ADDR_W-1:0] w_sel_idx;
    logic w_hit;

    assign w_rst_any = !reset || start[1];
    // Any start activity blocks grants so a request never straddles a page
    // change; it is granted on the next cycle against the new page.
    assign w_gnt_en  = en_proc && (start == 2'b00) && reset;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .clr   (start[1]),
        .en    (w_gnt_en),
        .req   ({req_b, req_a}),
        .gnt   (w_gnt)
    );

    assign gnt_a     = w_gnt[0];
    assign gnt_b     = w_gnt[1];
    assign w_any_gnt = |w_gnt;
    assign w_sel_idx = w_gnt[1] ? idx_b : idx_a;
    assign w_hit     = ({1'b0, w_sel_idx} < nent);

    // ------------------------------------------------------------------------
    // start delay
    // ------------------------------------------------------------------------
    logic [1:0] r_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_done <= 2'b00;
        end else begin
            r_done <= start;
        end
    end

    assign done = r_done;

    // ------------------------------------------------------------------------
    // Read page tracking (wraps naturally modulo 2^BX_W)
    // ------------------------------------------------------------------------
    logic [BX_W-1:0] r_rd_bx;

    always_ff @(posedge clk) begin
        if (w_rst_any) begin
            r_rd_bx <= c_bx_rst;
        end else if (start[0]) begin
            r_rd_bx <= r_rd_bx + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Read address: only in-range grants touch the memory
    // ------------------------------------------------------------------------
    logic [BX_W+ADDR_W-1:0] r_read_add;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_read_add <= '0;
        end else if (w_any_gnt && w_hit) begin
            r_read_add <= {r_rd_bx, w_sel_idx};
        end
    end

    assign read_add = r_read_add;

    // ------------------------------------------------------------------------
    // Tag pipeline: one stage for the address register plus RD_LAT stages for
    // the RAM, so the tag emerges aligned with mem_dout. Misses also enter so
    // that responses stay in grant order.
    // ------------------------------------------------------------------------
    trk_tag_t w_new_tag;
    trk_tag_t r_tag [0:RD_LAT];
    trk_tag_t w_out_tag;

    always_comb begin
        w_new_tag       = '0;
        w_new_tag.valid = w_any_gnt;
        w_new_tag.id    = w_gnt[1] ? REQ_B : REQ_A;
        w_new_tag.hit   = w_any_gnt & w_hit;
    end

    always_ff @(posedge clk) begin
        if (w_rst_any) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_new_tag;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_out_tag = r_tag[RD_LAT];

    assign vld_a = w_out_tag.valid && (w_out_tag.id == REQ_A);
    assign vld_b = w_out_tag.valid && (w_out_tag.id == REQ_B);
    assign hit_a = vld_a && w_out_tag.hit;
    assign hit_b = vld_b && w_out_tag.hit;
    // mem_dout is the RAM's registered output; a rejected index never read
    // the RAM, so its stale data is masked to zero.
    assign dout  = (w_out_tag.valid && w_out_tag.hit) ? mem_dout : '0;

    // ------------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------------
`ifdef TRKPAR_ARB_STATS_EN
    logic [15:0] r_stat_a;
    logic [15:0] r_stat_b;
    logic [15:0] r_stat_c;
    logic        w_contest;

    assign w_contest = w_gnt_en && req_a && req_b;

    always_ff @(posedge clk) begin
        if (w_rst_any || start[0]) begin
            r_stat_a <= '0;
            r_stat_b <= '0;
            r_stat_c <= '0;
        end else begin
            if (w_gnt[0] && (r_stat_a != c_stat_max)) begin
                r_stat_a <= r_stat_a + 16'd1;
            end
            if (w_gnt[1] && (r_stat_b != c_stat_max)) begin
                r_stat_b <= r_stat_b + 16'd1;
            end
            if (w_contest && (r_stat_c != c_stat_max)) begin
                r_stat_c <= r_stat_c + 16'd1;
            end
        end
    end

    assign stat_gnt_a    = r_stat_a;
    assign stat_gnt_b    = r_stat_b;
    assign stat_conflict = r_stat_c;
`endif

endmodule : tracklet_par_read_arbiter
`default_nettype wire

// File: tb/tb_tracklet_par_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tracklet_par_read_arbiter
//  Description : Directed self-checking bench for tracklet_par_read_arbiter
//                with a two-stage registered-output memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tracklet_par_read_arbiter;

    localparam int ADDR_W = 6;
    localparam int BX_W   = 5;
    localparam int DATA_W = 68;
    localparam int RD_LAT = 2;
    localparam int AW     = BX_W + ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              en_proc;
    logic [1:0]        start;
    logic [1:0]        done;
    logic [ADDR_W:0]   nent;
    logic              req_a, req_b;
    logic [ADDR_W-1:0] idx_a, idx_b;
    logic              gnt_a, gnt_b;
    logic [AW-1:0]     read_add;
    logic [DATA_W-1:0] mem_dout;
    logic              vld_a, vld_b, hit_a, hit_b;
    logic [DATA_W-1:0] dout;
`ifdef TRKPAR_ARB_STATS_EN
    logic [15:0]       stat_gnt_a, stat_gnt_b, stat_conflict;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tracklet_par_read_arbiter #(
        .ADDR_W (ADDR_W),
        .BX_W   (BX_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en_proc  (en_proc),
        .start    (start),
        .done     (done),
        .nent     (nent),
        .req_a    (req_a),
        .req_b    (req_b),
        .idx_a    (idx_a),
        .idx_b    (idx_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .read_add (read_add),
        .mem_dout (mem_dout),
        .vld_a    (vld_a),
        .vld_b    (vld_b),
        .hit_a    (hit_a),
        .hit_b    (hit_b),
        .dout     (dout)
`ifdef TRKPAR_ARB_STATS_EN
        ,
        .stat_gnt_a    (stat_gnt_a),
        .stat_gnt_b    (stat_gnt_b),
        .stat_conflict (stat_conflict)
`endif
    );

    // Memory word content is a recognisable function of its address
    function automatic logic [DATA_W-1:0] mem_word(input logic [AW-1:0] a);
        return {a, 46'h12_3456_789A, a};
    endfunction

    // Output-registered RAM: address sampled, then output register
    logic [DATA_W-1:0] r_m1, r_m2;
    always @(posedge clk) begin
        r_m1 <= mem_word(read_add);
        r_m2 <= r_m1;
    end
    assign mem_dout = r_m2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [AW-1:0] exp_add;

    initial begin
        reset = 1'b0; en_proc = 1'b0; start = 2'b00; nent = '0;
        req_a = 1'b1; req_b = 1'b0; idx_a = '0; idx_b = '0;

        // ---------------- reset state ----------------
        tick(); tick(); en_proc = 1'b1; settle();
        chk("rst_gnt_a", gnt_a, 1'b0);
        chk("rst_gnt_b", gnt_b, 1'b0);
        chk("rst_read_add", read_add, '0);
        chk("rst_vld", {vld_a, vld_b, hit_a, hit_b}, 4'b0000);
        chk("rst_dout", dout, '0);
        chk("rst_done", done, 2'b00);

        // en_proc low blocks grants
        tick(); reset = 1'b1; en_proc = 1'b0; req_a = 1'b1; settle();
        chk("noen_gnt_a", gnt_a, 1'b0);

        // ---------------- single hit read ----------------
        tick(); en_proc = 1'b1; req_a = 1'b0; start = 2'b01;
        tick(); start = 2'b00; nent = 7'd4; req_a = 1'b1; idx_a = 6'd2; settle();
        chk("done_after_start", done, 2'b01);
        chk("t1_gnt_a", gnt_a, 1'b1);
        chk("t1_gnt_b", gnt_b, 1'b0);
        tick(); req_a = 1'b0; settle();
        chk("t1_read_add", read_add, 11'h7C2);
        tick();
        chk("t1_vld_early", vld_a, 1'b0);
        tick();
        chk("t1_vld_a", vld_a, 1'b1);
        chk("t1_hit_a", hit_a, 1'b1);
        chk("t1_vld_b", vld_b, 1'b0);
        chk("t1_dout", dout, mem_word(11'h7C2));
        tick();
        chk("t1_vld_pulse", vld_a, 1'b0);

        // ---------------- contested requests, 4 cycles ----------------
        nent = 7'd8; idx_a = 6'd1; idx_b = 6'd5;
        for (int k = 0; k < 7; k++) begin
            req_a = (k < 4); req_b = (k < 4); settle();
            if (k < 4) begin
                chk($sformatf("rr_gnt_a_%0d", k), gnt_a, (k % 2) == 0);
                chk($sformatf("rr_gnt_b_%0d", k), gnt_b, (k % 2) == 1);
            end
            if (k >= 1 && k <= 4) begin
                exp_add = ((k % 2) == 1) ? 11'h7C1 : 11'h7C5;
                chk($sformatf("rr_add_%0d", k), read_add, exp_add);
            end
            if (k >= 3) begin
                chk($sformatf("rr_vld_a_%0d", k), vld_a, ((k - 3) % 2) == 0);
                chk($sformatf("rr_vld_b_%0d", k), vld_b, ((k - 3) % 2) == 1);
                exp_add = (((k - 3) % 2) == 0) ? 11'h7C1 : 11'h7C5;
                chk($sformatf("rr_dout_%0d", k), dout, mem_word(exp_add));
            end
            tick();
        end

        // ---------------- out-of-range index (idx == nent) ----------------
        nent = 7'd3; req_b = 1'b1; idx_b = 6'd3; settle();
        chk("miss_gnt_b", gnt_b, 1'b1);
        tick(); req_b = 1'b0; settle();
        chk("miss_read_add_held", read_add, 11'h7C5);
        tick(); tick();
        chk("miss_vld_b", vld_b, 1'b1);
        chk("miss_hit_b", hit_b, 1'b0);
        chk("miss_dout", dout, '0);

        // nent = 0 rejects even index 0
        tick(); nent = 7'd0; req_a = 1'b1; idx_a = 6'd0; settle();
        chk("nent0_gnt_a", gnt_a, 1'b1);
        tick(); req_a = 1'b0; tick(); tick();
        chk("nent0_vld_a", vld_a, 1'b1);
        chk("nent0_hit_a", hit_a, 1'b0);

        // ---------------- pipelined reset drops in-flight ----------------
        tick(); nent = 7'd8; req_a = 1'b1; idx_a = 6'd0;
        tick(); req_a = 1'b0; req_b = 1'b1; idx_b = 6'd1;
        tick(); req_b = 1'b0; start = 2'b11; settle();
        chk("prst_no_gnt", {gnt_a, gnt_b}, 2'b00);
        tick(); start = 2'b00; req_a = 1'b1; idx_a = 6'd3; settle();
        chk("prst_done", done, 2'b11);
        chk("prst_drop_0", {vld_a, vld_b}, 2'b00);
        chk("prst_gnt_a", gnt_a, 1'b1);
        tick(); req_a = 1'b0; settle();
        chk("prst_drop_1", {vld_a, vld_b}, 2'b00);
        chk("prst_rd_bx", read_add, 11'h783);
        tick();
        chk("prst_drop_2", {vld_a, vld_b}, 2'b00);
        tick();
        chk("prst_vld_a", vld_a, 1'b1);
        chk("prst_dout", dout, mem_word(11'h783));

        // ---------------- start[0] with pending request ----------------
        tick(); start = 2'b01; req_a = 1'b1; idx_a = 6'd4; settle();
        chk("st_gnt_blocked", gnt_a, 1'b0);
        tick(); start = 2'b00; settle();
        chk("st_gnt_next", gnt_a, 1'b1);
        tick(); req_a = 1'b0; settle();
        chk("st_read_add", read_add, 11'h7C4);

        // wrap 11111 -> 00000
        start = 2'b01;
        tick(); start = 2'b00; req_a = 1'b1;
        tick(); req_a = 1'b0; settle();
        chk("wrap_zero", read_add, 11'h004);
        for (int p = 0; p < 31; p++) begin
            start = 2'b01;
            tick();
        end
        start = 2'b00; req_a = 1'b1;
        tick(); req_a = 1'b0; settle();
        chk("wrap_full", read_add, 11'h7C4);

`ifdef TRKPAR_ARB_STATS_EN
        // ---------------- statistics ----------------
        tick(); start = 2'b01;
        tick(); start = 2'b00; settle();
        chk("stat_clear_pre", stat_conflict, 16'd0);
        req_a = 1'b1; req_b = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        req_a = 1'b0; req_b = 1'b0; settle();
        chk("stat_conflict", stat_conflict, 16'd10);
        chk("stat_gnt_a", stat_gnt_a, 16'd5);
        chk("stat_gnt_b", stat_gnt_b, 16'd5);
        start = 2'b01;
        tick(); start = 2'b00; settle();
        chk("stat_clr", {stat_gnt_a, stat_gnt_b, stat_conflict}, 48'd0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_tracklet_par_read_arbiter
`default_nettype wire
